// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - default sizes and FSM state type shared by the burst memory
package mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_LANES  = 4;
  localparam int MEM_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_burst_ctrl_if.sv
// rtl/mem_burst_ctrl_if.sv - command, write and read-stream bundle of the burst memory
interface mem_burst_ctrl_if import mem_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LANES  = MEM_LANES,
  parameter int LEN_W  = MEM_LEN_W
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDR_W-1:0]       cmd_addr;
  logic [LEN_W-1:0]        cmd_len;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [LANES*DATA_W-1:0] wr_data;
  logic [LANES-1:0]        wr_mask;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [LANES*DATA_W-1:0] rd_data;
  logic                    rd_last;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, wr_mask,
    output rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, wr_mask,
    input  rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy
  );

endinterface

// File: rtl/ram_bank.sv
// rtl/ram_bank.sv - one lane of the scratchpad: single-port RAM with registered read
module ram_bank import mem_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clock,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // enabled access: optional write plus read-before-write into the output register
  always_ff @(posedge clock) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - multi-lane burst scratchpad with backpressured read stream
module mem_burst_ctrl import mem_pkg::*; #(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int LANES  = MEM_LANES,
  parameter int LEN_W  = MEM_LEN_W
) (
  input logic             clock,
  input logic             reset_n,
  mem_burst_ctrl_if.slave bus
);

  localparam int ROW_W = LANES * DATA_W;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_cmd_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_remain;
  logic              r_inflight;
  logic              r_inflight_last;
  logic [ROW_W-1:0]  r_fifo_data [2];
  logic              r_fifo_last [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;

  logic              w_cmd_fire;
  logic              w_wr_fire;
  logic              w_wr_ready;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_busy;
  logic              w_rd_valid;
  logic              w_cur_last;
  logic              w_pop;
  logic              w_pop_fifo;
  logic              w_push;
  logic              w_bank_en;
  logic [ROW_W-1:0]  w_ram_row;
  logic [DATA_W-1:0] w_bank_q [LANES];

  assign w_cmd_fire   = bus.cmd_valid & r_cmd_ready;
  assign w_wr_fire    = bus.wr_valid & w_wr_ready;
  assign w_issue_last = w_issue & (r_remain == '0);

  // The RAM output register acts as a bypass stage in front of the FIFO, so a
  // beat is visible the cycle after its issue even when the FIFO is empty.
  assign w_rd_valid = (r_count != 2'd0) | r_inflight;
  assign w_cur_last = (r_count != 2'd0) ? r_fifo_last[r_rptr] : r_inflight_last;
  assign w_pop      = w_rd_valid & bus.rd_ready;
  assign w_pop_fifo = w_pop & (r_count != 2'd0);
  assign w_push     = r_inflight & ~(w_pop & (r_count == 2'd0));

  // reset gates the RAM so a beat offered on the reset edge never lands
  assign w_bank_en = (w_wr_fire | w_issue) & reset_n;

  // state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_cmd_fire) w_next_state = bus.cmd_write ? WRITE : READ;
      WRITE:   if (w_wr_fire && (r_remain == '0)) w_next_state = IDLE;
      READ:    if (w_issue_last) w_next_state = DRAIN;
      DRAIN:   if (w_pop && w_cur_last) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // state-derived outputs; a read is issued only while a free slot is guaranteed
  always_comb begin
    w_wr_ready = 1'b0;
    w_issue    = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      IDLE:    w_busy = 1'b0;
      WRITE:   w_wr_ready = 1'b1;
      READ:    w_issue = (({1'b0, r_count} + {2'b00, r_inflight}) < 3'd2);
      default: ;
    endcase
  end

  // registered command ready: high whenever the FSM will sit in IDLE next cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (w_next_state == IDLE);
    end
  end

  // row address and remaining-beat counter, wrapping modulo the bank depth
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_addr   <= '0;
      r_remain <= '0;
    end else if (w_cmd_fire) begin
      r_addr   <= bus.cmd_addr;
      r_remain <= bus.cmd_len;
    end else if (w_wr_fire || w_issue) begin
      r_addr   <= r_addr + ADDR_W'(1);
      r_remain <= r_remain - LEN_W'(1);
    end
  end

  // in-flight flag tracks the RAM output register holding a fresh row
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
    end
  end

  // output FIFO pointers and occupancy
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push)     r_wptr <= ~r_wptr;
      if (w_pop_fifo) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop_fifo};
    end
  end

  // output FIFO storage captures a RAM row that was not consumed directly
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= w_ram_row;
      r_fifo_last[r_wptr] <= r_inflight_last;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ram_bank #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_bank (
      .clock   (clock),
      .i_en    (w_bank_en),
      .i_we    (w_wr_fire & bus.wr_mask[g]),
      .i_addr  (r_addr),
      .i_wdata (bus.wr_data[g*DATA_W +: DATA_W]),
      .o_rdata (w_bank_q[g])
    );
    assign w_ram_row[g*DATA_W +: DATA_W] = w_bank_q[g];
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.rd_valid  = w_rd_valid;
  assign bus.rd_data   = !w_rd_valid ? '0 :
                         (r_count != 2'd0) ? r_fifo_data[r_rptr] : w_ram_row;
  assign bus.rd_last   = w_rd_valid & w_cur_last;
  assign bus.busy      = w_busy;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - directed self-checking bench for mem_burst_ctrl
module tb_mem_burst_ctrl;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int LEN_W  = 8;
  localparam int ROW_W  = LANES * DATA_W;

  logic clk = 1'b0;
  logic reset_n;

  int checks   = 0;
  int failures = 0;

  logic [ROW_W-1:0] wbuf [16];
  logic [LANES-1:0] wmsk [16];
  logic [ROW_W-1:0] rbuf [16];
  logic             rlast_buf [16];
  bit               rdy_pat [300];
  int               rcount;
  int               first_k;
  int               last_k;
  int               extra_beats;
  logic             ready_after;

  mem_burst_ctrl_if #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LANES (LANES), .LEN_W (LEN_W)
  ) bus ();

  mem_burst_ctrl #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .LANES (LANES), .LEN_W (LEN_W)
  ) dut (
    .clock   (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // lane i of row r holds base + r*11 + 3 + i
  function automatic logic [ROW_W-1:0] row_pat(input int r, input int base);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = 16'(base + r * 11 + 3 + i);
    return v;
  endfunction

  task automatic issue_cmd(input logic wr, input int addr, input int len, output bit ok);
    int n;
    ok = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = ADDR_W'(addr);
    bus.cmd_len   = LEN_W'(len);
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL cmd_timeout: cmd_ready=%b required 1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic write_burst(input int addr, input int len, input int nbeats);
    bit ok;
    int n;
    issue_cmd(1'b1, addr, len, ok);
    if (!ok) return;
    for (int b = 0; b < nbeats && b <= len; b++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wbuf[b];
      bus.wr_mask  = wmsk[b];
      n = 0;
      while (bus.wr_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (bus.wr_ready !== 1'b1) begin
        checks++; failures++;
        $display("FAIL wr_timeout: wr_ready=%b required 1 at beat %0d", bus.wr_ready, b);
        break;
      end
      @(negedge clk);
    end
    bus.wr_valid = 1'b0;
  endtask

  task automatic read_burst(input int addr, input int len, input bit use_pat);
    bit               ok;
    bit               prev_stall;
    logic [ROW_W-1:0] prev_data;
    logic             prev_last;
    int               k;
    rcount = 0; first_k = -1; last_k = -1; extra_beats = 0;
    prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    issue_cmd(1'b0, addr, len, ok);
    if (!ok) return;
    k = 0;
    while (rcount <= len && k < 300) begin
      if (k > 0) @(negedge clk);
      bus.rd_ready = use_pat ? rdy_pat[k] : 1'b1;
      if (bus.rd_valid === 1'b1 && first_k < 0) first_k = k;
      if (prev_stall) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== prev_data || bus.rd_last !== prev_last) begin
          failures++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                   bus.rd_valid, bus.rd_data, bus.rd_last, prev_data, prev_last);
        end
      end
      if (bus.rd_valid === 1'b1 && bus.rd_ready === 1'b1) begin
        if (rcount < 16) begin
          rbuf[rcount]      = bus.rd_data;
          rlast_buf[rcount] = bus.rd_last;
        end
        rcount++;
        last_k = k;
        prev_stall = 1'b0;
      end else begin
        prev_stall = (bus.rd_valid === 1'b1);
        prev_data  = bus.rd_data;
        prev_last  = bus.rd_last;
      end
      k++;
    end
    @(negedge clk);
    ready_after  = bus.cmd_ready;
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (bus.rd_valid === 1'b1) extra_beats++;
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (rcount != len + 1 || extra_beats != 0) begin
      failures++;
      $display("FAIL beat_count: got %0d beats plus %0d extra, required %0d", rcount, extra_beats, len + 1);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: {cmd_ready,wr_ready,rd_valid,rd_last,busy}=%b required 00000",
               {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy});
    end
    checks++;
    if (bus.rd_data !== '0) begin
      failures++;
      $display("FAIL reset_rd_data: %h required 0", bus.rd_data);
    end
    reset_n = 1'b1;
    checks++;
    if (bus.cmd_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_cmd_ready_early: %b required 0", bus.cmd_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready_rise: %b required 1", bus.cmd_ready);
    end
  endtask

  task automatic test_burst;
    for (int r = 0; r < 8; r++) begin
      wbuf[r] = row_pat(r, 0);
      wmsk[r] = 4'hF;
    end
    write_burst(0, 7, 8);
    read_burst(0, 7, 1'b0);
    checks++;
    if (first_k != 1) begin
      failures++;
      $display("FAIL burst_latency: first rd_valid after %0d edges, required 1", first_k);
    end
    checks++;
    if (last_k != 8) begin
      failures++;
      $display("FAIL burst_throughput: last handshake at edge N+%0d, required N+9", last_k + 1);
    end
    checks++;
    if (ready_after !== 1'b1) begin
      failures++;
      $display("FAIL burst_cmd_ready: %b required 1", ready_after);
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rbuf[b] !== row_pat(b, 0) || rlast_buf[b] !== (b == 7)) begin
        failures++;
        $display("FAIL burst_beat%0d: data=%h last=%b required data=%h last=%b",
                 b, rbuf[b], rlast_buf[b], row_pat(b, 0), (b == 7));
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int r = 0; r < 8; r++) begin
      wbuf[r] = row_pat(r, 'h4000);
      wmsk[r] = 4'hF;
    end
    write_burst(0, 7, 3);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy: %b required 1", bus.busy);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL mid_reset_ctrl: {cmd_ready,wr_ready,rd_valid,rd_last,busy}=%b required 00000",
               {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.rd_last, bus.busy});
    end
    checks++;
    if (bus.rd_data !== '0) begin
      failures++;
      $display("FAIL mid_reset_rd_data: %h required 0", bus.rd_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_cmd_ready: %b required 1", bus.cmd_ready);
    end
    read_burst(0, 7, 1'b0);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (rbuf[b] !== ((b < 3) ? row_pat(b, 'h4000) : row_pat(b, 0))) begin
        failures++;
        $display("FAIL mid_row%0d: %h required %h", b, rbuf[b],
                 (b < 3) ? row_pat(b, 'h4000) : row_pat(b, 0));
      end
    end
  endtask

  task automatic test_mask;
    wbuf[0] = {4{16'hAAAA}};
    wmsk[0] = 4'hF;
    write_burst(5, 0, 1);
    wbuf[0] = {4{16'h5555}};
    wmsk[0] = 4'b0101;
    write_burst(5, 0, 1);
    read_burst(5, 0, 1'b0);
    checks++;
    if (rbuf[0] !== 64'hAAAA_5555_AAAA_5555 || rlast_buf[0] !== 1'b1) begin
      failures++;
      $display("FAIL mask_row5: data=%h last=%b required data=aaaa5555aaaa5555 last=1", rbuf[0], rlast_buf[0]);
    end
    wbuf[0] = {4{16'hFFFF}};
    wmsk[0] = 4'h0;
    write_burst(5, 0, 1);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL mask_zero_consumed: cmd_ready=%b required 1", bus.cmd_ready);
    end
    bus.wr_valid = 1'b1;
    bus.wr_data  = '0;
    bus.wr_mask  = 4'hF;
    checks++;
    if (bus.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_wr_ready: %b required 0", bus.wr_ready);
    end
    repeat (2) @(negedge clk);
    bus.wr_valid = 1'b0;
    read_burst(5, 0, 1'b0);
    checks++;
    if (rbuf[0] !== 64'hAAAA_5555_AAAA_5555) begin
      failures++;
      $display("FAIL mask_unchanged: %h required aaaa5555aaaa5555", rbuf[0]);
    end
  endtask

  task automatic test_wrap;
    for (int b = 0; b < 4; b++) begin
      wbuf[b] = row_pat(b, 'h7000);
      wmsk[b] = 4'hF;
    end
    write_burst(4094, 3, 4);
    read_burst(4094, 3, 1'b0);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (rbuf[b] !== row_pat(b, 'h7000) || rlast_buf[b] !== (b == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d: data=%h last=%b required data=%h last=%b",
                 b, rbuf[b], rlast_buf[b], row_pat(b, 'h7000), (b == 3));
      end
    end
    read_burst(0, 0, 1'b0);
    checks++;
    if (rbuf[0] !== row_pat(2, 'h7000)) begin
      failures++;
      $display("FAIL wrap_row0: %h required %h", rbuf[0], row_pat(2, 'h7000));
    end
  endtask

  task automatic test_backpressure;
    for (int b = 0; b < 16; b++) begin
      wbuf[b] = row_pat(b, 'h2000);
      wmsk[b] = 4'hF;
    end
    write_burst(200, 15, 16);
    read_burst(200, 15, 1'b1);
    for (int b = 0; b < 16; b++) begin
      checks++;
      if (rbuf[b] !== row_pat(b, 'h2000) || rlast_buf[b] !== (b == 15)) begin
        failures++;
        $display("FAIL bp_beat%0d: data=%h last=%b required data=%h last=%b",
                 b, rbuf[b], rlast_buf[b], row_pat(b, 'h2000), (b == 15));
      end
    end
  endtask

  task automatic test_back_to_back;
    wbuf[0] = {4{16'h1234}};
    wmsk[0] = 4'hF;
    write_burst(10, 0, 1);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_cmd_ready: %b required 1", bus.cmd_ready);
    end
    read_burst(10, 0, 1'b0);
    checks++;
    if (rbuf[0] !== {4{16'h1234}} || first_k != 1) begin
      failures++;
      $display("FAIL b2b_row10: data=%h first_valid=%0d required data=1234123412341234 first_valid=1",
               rbuf[0], first_k);
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_mask   = '0;
    bus.rd_ready  = 1'b0;
    for (int i = 0; i < 300; i++) rdy_pat[i] = 1'($urandom_range(0, 1));
    rdy_pat[0] = 1'b1;
    rdy_pat[1] = 1'b1;
    rdy_pat[2] = 1'b0;
    rdy_pat[3] = 1'b0;
    rdy_pat[4] = 1'b1;
    rdy_pat[5] = 1'b0;
    test_reset;
    test_burst;
    test_reset_mid;
    test_mask;
    test_wrap;
    test_backpressure;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
